// File: rtl/adpcm_stream_ctrl.sv
// adpcm_stream_ctrl: sequencer for the CIC+ADPCM compressor datapath.
// Generates the decimation clock (slow_clk) and block enable, and runs an
// IDLE/WARMUP/RUN/DRAIN session. Samples produced while the CIC settles are
// discarded, then 4-bit codes are packed two per byte into a first-word
// fall-through FIFO feeding a valid/ready byte stream.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   start, stop, div      session control pulses, slow_clk half-period - 1
//   slow_clk, block_enable compressor clock and enable
//   enc_valid, enc_pcm    compressor sample strobe (level) and 4-bit code
//   byte_data/valid/ready downstream byte stream
//   busy, overflow        not-idle status, sticky byte-drop flag
module adpcm_stream_ctrl #(
  parameter int DIV_W      = 8,
  parameter int WARMUP     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  output logic             slow_clk,
  output logic             block_enable,
  input  logic             enc_valid,
  input  logic [3:0]       enc_pcm,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy,
  output logic             overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_DRAIN} state_e;

  state_e                         state_q, state_d;
  logic [DIV_W-1:0]               div_lat_q, div_lat_d;
  logic [DIV_W-1:0]               cnt_q, cnt_d;
  logic                           slow_q, slow_d;
  logic                           ben_q, ben_d;
  logic                           busy_q, busy_d;
  logic                           ovf_q, ovf_d;
  logic                           enc_valid_q, enc_valid_d;
  logic [WW-1:0]                  disc_q, disc_d;
  logic [3:0]                     hold_q, hold_d;
  logic                           hold_vld_q, hold_vld_d;
  logic [FIFO_DEPTH-1:0][7:0]     mem_q, mem_d;
  logic [AW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                  count_q, count_d;

  logic       sample, pop, push, accept, run_div;
  logic [7:0] push_byte;

  always_comb begin
    state_d     = state_q;
    div_lat_d   = div_lat_q;
    cnt_d       = cnt_q;
    slow_d      = slow_q;
    ovf_d       = ovf_q;
    disc_d      = disc_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    enc_valid_d = enc_valid;
    push        = 1'b0;
    push_byte   = 8'h00;
    accept      = 1'b0;

    // One sample per rising edge of the level-valid from the encoder.
    sample = enc_valid & ~enc_valid_q;
    pop    = (count_q != '0) & byte_ready;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WARMUP;
          div_lat_d  = div;
          ovf_d      = 1'b0;
          disc_d     = '0;
          hold_vld_d = 1'b0;
        end
      end
      S_WARMUP: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (sample) begin
          disc_d = disc_q + WW'(1);
          if (disc_q == WW'(WARMUP - 1)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (sample) begin
          if (hold_vld_q) begin
            push       = 1'b1;
            push_byte  = {enc_pcm, hold_q};
            hold_vld_d = 1'b0;
          end else begin
            hold_d     = enc_pcm;
            hold_vld_d = 1'b1;
          end
        end
        if (stop) state_d = S_DRAIN;
      end
      default: begin // S_DRAIN
        // A half-filled holder is flushed once as a zero-padded byte.
        if (hold_vld_q) begin
          push       = 1'b1;
          push_byte  = {4'h0, hold_q};
          hold_vld_d = 1'b0;
        end else if (count_q == '0) begin
          state_d = S_IDLE;
        end
      end
    endcase

    // FIFO: a pop in the same cycle frees the slot for a push into a full FIFO.
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) begin
      if ((count_q != CW'(FIFO_DEPTH)) || pop) begin
        accept          = 1'b1;
        mem_d[wr_ptr_q] = push_byte;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        ovf_d      = 1'b1;
        hold_vld_d = 1'b0;
      end
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Divider only runs while staying in WARMUP/RUN, so the count starts at 0
    // on entry and slow_clk drops to 0 on the edge that leaves those states.
    run_div = ((state_q == S_WARMUP) || (state_q == S_RUN)) &&
              ((state_d == S_WARMUP) || (state_d == S_RUN));
    if (run_div) begin
      if (cnt_q == div_lat_q) begin
        cnt_d  = '0;
        slow_d = ~slow_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d  = '0;
      slow_d = 1'b0;
    end

    ben_d  = (state_d == S_WARMUP) || (state_d == S_RUN);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_lat_q   <= '0;
      cnt_q       <= '0;
      slow_q      <= 1'b0;
      ben_q       <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      enc_valid_q <= 1'b0;
      disc_q      <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      div_lat_q   <= div_lat_d;
      cnt_q       <= cnt_d;
      slow_q      <= slow_d;
      ben_q       <= ben_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      enc_valid_q <= enc_valid_d;
      disc_q      <= disc_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign slow_clk     = slow_q;
  assign block_enable = ben_q;
  assign busy         = busy_q;
  assign overflow     = ovf_q;
  assign byte_valid   = (count_q != '0);
  assign byte_data    = byte_valid ? mem_q[rd_ptr_q] : 8'h00;
endmodule
